jtag_uart_sys_cpu_oci_dct_packer: RTL and testbench
===================================================

JTAG_UART_SYS_CPU_OCI_DCT_PACKER -- requirements
Module: jtag_uart_sys_cpu_oci_dct_packer

Interface
REQ-001 Parameter ENTRY_W, default 2, bits per direct-control-transfer (DCT) code.
REQ-002 Parameter DEPTH, default 15, entries per packet; BUF_W = ENTRY_W*DEPTH = 30.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 trc_enb  input  1  trace enable; dct_valid and flush are ignored while low.
REQ-006 dct_valid  input  1  one DCT code offered this cycle.
REQ-007 dct_code  input  2  01 = conditional not taken, 10 = conditional taken, 11 = unconditional direct; 00 reserved.
REQ-008 flush  input  1  force emission of a partial packet (indirect transfer, exception).
REQ-009 pkt_ready  input  1  downstream accepts the packet.
REQ-010 dct_buffer  output  30  live fill buffer, newest code in [1:0].
REQ-011 dct_count  output  4  live number of valid entries, 0..15.
REQ-012 pkt_valid  output  1  packet slot holds a packet.
REQ-013 pkt_buffer  output  30  packet payload.
REQ-014 pkt_count  output  4  packet entry count, 1..15.
REQ-015 overflow  output  1  sticky: at least one packet dropped.
REQ-016 lost_cnt  output  8  number of dropped packets, saturating at 255.

Function
REQ-017 An accept occurs when trc_enb & dct_valid & (dct_code != 00); code 00 is discarded without side effects.
REQ-018 On accept: dct_buffer <= {dct_buffer[27:0], dct_code}; dct_count increments; both are visible 1 cycle later.
REQ-019 An emit occurs when dct_count reaches 15 through an accept, or on trc_enb & flush with a post-accept count > 0.
REQ-020 On emit: the slot is loaded with the post-accept buffer and count in the same edge; dct_buffer <= 0 and dct_count <= 0.
REQ-021 An accept and a flush in the same cycle include that code in the emitted packet.
REQ-022 A flush with count 0 and no accept in the same cycle emits nothing.
REQ-023 A 1->0 transition of trc_enb with count > 0 is an implicit flush on the following cycle; partial contents are never discarded silently.
REQ-024 The slot FSM has two states. SLOT_EMPTY -> SLOT_FULL on emit. SLOT_FULL -> SLOT_EMPTY on pkt_ready with no emit. SLOT_FULL stays SLOT_FULL on pkt_ready with an emit, and the new packet replaces the old one with no bubble.
REQ-025 An emit in SLOT_FULL without pkt_ready drops the new packet and keeps the held packet stable.
REQ-026 A drop sets overflow and increments lost_cnt, which saturates at 255; the fill buffer is still cleared.
REQ-027 pkt_buffer and pkt_count hold stable while pkt_valid=1 and pkt_ready=0.
REQ-028 Unused upper entries of a partial packet read 0.

Reset
REQ-029 reset_n=0 at a clock edge clears dct_buffer, dct_count, pkt_valid, pkt_buffer, pkt_count, overflow and lost_cnt to 0, and sets the slot FSM to SLOT_EMPTY.
REQ-030 Reset has priority over every simultaneous accept, flush or handshake.
REQ-031 Reset mid-packet discards the partial and held packets without counting a drop.
REQ-032 The first accept is possible in the first cycle with reset_n=1.

Structure
REQ-033 Package jtag_uart_sys_cpu_oci_dct_pkg holds the DCT code constants (NT, TK, UNC, RSVD), ENTRY_W, DEPTH, BUF_W and the slot-state enumeration.
REQ-034 The slot FSM and its payload registers are in sub-module jtag_uart_sys_cpu_oci_dct_outreg; the fill logic and drop counters are in the top level.
REQ-035 dct_buffer and dct_count connect unchanged to the existing OCI test-bench inputs of the same names.

Verification
REQ-036 15 accepts of code 10 with pkt_ready=1: one cycle after the 15th accept, pkt_valid=1, pkt_buffer=30'h2AAAAAAA, pkt_count=15, dct_count=0.
REQ-037 Accepts 01, 11, 10 followed by flush: pkt_count=3, pkt_buffer=30'h0000001E; a flush with count 0 leaves pkt_valid=0.
REQ-038 Accept and flush in the same cycle, with 4 entries already buffered: pkt_count=5.
REQ-039 pkt_ready=0 and two packets emitted: the first packet is held unchanged, overflow=1, lost_cnt=1; 300 further drops leave lost_cnt=255.
REQ-040 Slot full, pkt_ready=1 and an emit in the same cycle: pkt_valid stays 1, the payload updates, lost_cnt=0.
REQ-041 reset_n=0 for one cycle with count 7 and a held packet: all outputs read 0 on the next cycle; dct_code=00 while dct_valid=1 leaves dct_count unchanged.

Source files
------------

// File: rtl/jtag_uart_sys_cpu_oci_dct_pkg.sv
// Shared constants and types for the OCI direct-control-transfer trace packer.
package jtag_uart_sys_cpu_oci_dct_pkg;

    localparam int unsigned ENTRY_W = 2;
    localparam int unsigned DEPTH   = 15;
    localparam int unsigned BUF_W   = ENTRY_W * DEPTH;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    // DCT code points; RSVD is never stored
    localparam logic [ENTRY_W-1:0] RSVD = 2'b00;
    localparam logic [ENTRY_W-1:0] NT   = 2'b01;
    localparam logic [ENTRY_W-1:0] TK   = 2'b10;
    localparam logic [ENTRY_W-1:0] UNC  = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/jtag_uart_sys_cpu_oci_dct_outreg.sv
// Single-entry packet slot: holds the last emitted packet until downstream takes it.
module jtag_uart_sys_cpu_oci_dct_outreg #(
    parameter int unsigned PAY_W = 30,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             emit,
    input  logic [PAY_W-1:0] emit_buffer,
    input  logic [LEN_W-1:0] emit_count,
    input  logic             pkt_ready,
    output logic             pkt_valid,
    output logic [PAY_W-1:0] pkt_buffer,
    output logic [LEN_W-1:0] pkt_count
);
    import jtag_uart_sys_cpu_oci_dct_pkg::*;

    slot_state_e state_q;
    slot_state_e state_d;
    logic        load_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // An emit into a full slot only lands when the held packet leaves in the same cycle
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            SLOT_EMPTY: begin
                if (emit) begin
                    state_d = SLOT_FULL;
                    load_c  = 1'b1;
                end
            end
            SLOT_FULL: begin
                if (pkt_ready) begin
                    if (emit) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = SLOT_EMPTY;
                    end
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pkt_buffer <= '0;
            pkt_count  <= '0;
        end else if (load_c) begin
            pkt_buffer <= emit_buffer;
            pkt_count  <= emit_count;
        end
    end

    assign pkt_valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/jtag_uart_sys_cpu_oci_dct_packer.sv
// Packs DCT codes into fixed-depth trace packets and hands them to a one-entry slot.
module jtag_uart_sys_cpu_oci_dct_packer #(
    parameter int unsigned ENTRY_W = jtag_uart_sys_cpu_oci_dct_pkg::ENTRY_W,
    parameter int unsigned DEPTH   = jtag_uart_sys_cpu_oci_dct_pkg::DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         trc_enb,
    input  logic                         dct_valid,
    input  logic [ENTRY_W-1:0]           dct_code,
    input  logic                         flush,
    input  logic                         pkt_ready,
    output logic [ENTRY_W*DEPTH-1:0]     dct_buffer,
    output logic [$clog2(DEPTH+1)-1:0]   dct_count,
    output logic                         pkt_valid,
    output logic [ENTRY_W*DEPTH-1:0]     pkt_buffer,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic                         overflow,
    output logic [7:0]                   lost_cnt
);
    import jtag_uart_sys_cpu_oci_dct_pkg::*;

    localparam int unsigned FILL_W   = ENTRY_W * DEPTH;
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    logic              trc_enb_q;
    logic              accept;
    logic              flush_any;
    logic              emit;
    logic              drop;
    logic [FILL_W-1:0] post_buffer;
    logic [CNT_BITS-1:0] post_count;

    // Post-accept view of the fill buffer; this is what an emit captures
    always_comb begin
        accept      = trc_enb & dct_valid & (dct_code != ENTRY_W'(RSVD));
        post_buffer = dct_buffer;
        post_count  = dct_count;
        if (accept) begin
            post_buffer = {dct_buffer[FILL_W-ENTRY_W-1:0], dct_code};
            post_count  = dct_count + CNT_BITS'(1);
        end
        // Trace being switched off must not strand a partial packet
        flush_any = (trc_enb & flush) | (trc_enb_q & ~trc_enb);
        emit      = (accept & (post_count == CNT_BITS'(DEPTH)))
                  | (flush_any & (post_count != '0));
        drop      = emit & pkt_valid & ~pkt_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trc_enb_q  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            overflow   <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            trc_enb_q <= trc_enb;
            if (emit) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (accept) begin
                dct_buffer <= post_buffer;
                dct_count  <= post_count;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (lost_cnt != 8'hFF) begin
                    lost_cnt <= lost_cnt + 8'd1;
                end
            end
        end
    end

    jtag_uart_sys_cpu_oci_dct_outreg #(
        .PAY_W (FILL_W),
        .LEN_W (CNT_BITS)
    ) u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .emit        (emit),
        .emit_buffer (post_buffer),
        .emit_count  (post_count),
        .pkt_ready   (pkt_ready),
        .pkt_valid   (pkt_valid),
        .pkt_buffer  (pkt_buffer),
        .pkt_count   (pkt_count)
    );

endmodule

// File: tb/tb_jtag_uart_sys_cpu_oci_dct_packer.sv
// Scoreboard bench for the DCT packer: a cycle model predicts packets, the slot output is compared on handshake.
module tb_jtag_uart_sys_cpu_oci_dct_packer;

    typedef struct packed {
        logic [29:0] b;
        logic [3:0]  c;
    } pkt_t;

    logic        clk;
    logic        reset_n;
    logic        trc_enb;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        pkt_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [29:0] pkt_buffer;
    logic [3:0]  pkt_count;
    logic        overflow;
    logic [7:0]  lost_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [29:0] m_buf;
    int          m_cnt;
    logic        m_full;
    logic        m_ovf;
    int          m_lost;
    logic        m_prev_enb;
    pkt_t        sb[$];

    jtag_uart_sys_cpu_oci_dct_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_enb    (trc_enb),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .flush      (flush),
        .pkt_ready  (pkt_ready),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .pkt_valid  (pkt_valid),
        .pkt_buffer (pkt_buffer),
        .pkt_count  (pkt_count),
        .overflow   (overflow),
        .lost_cnt   (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_buf      = '0;
        m_cnt      = 0;
        m_full     = 1'b0;
        m_ovf      = 1'b0;
        m_lost     = 0;
        m_prev_enb = 1'b0;
        sb.delete();
    endtask

    // One clock: drive inputs, retire a handshaken packet, advance the model, check live outputs
    task automatic cycle(input logic enb, input logic vld, input logic [1:0] code,
                         input logic flsh, input logic rdy);
        logic        acc;
        logic        fl;
        logic        em;
        logic [29:0] pb;
        int          pc;
        pkt_t        exp_pkt;
        pkt_t        new_pkt;
        trc_enb   = enb;
        dct_valid = vld;
        dct_code  = code;
        flush     = flsh;
        pkt_ready = rdy;
        check_eq("pkt_valid_pre", 32'(pkt_valid), 32'(m_full));
        if (m_full && rdy) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                exp_pkt = sb.pop_front();
                check_eq("pkt_buffer", 32'(pkt_buffer), 32'(exp_pkt.b));
                check_eq("pkt_count", 32'(pkt_count), 32'(exp_pkt.c));
            end
        end
        acc = enb && vld && (code != 2'b00);
        pb  = acc ? {m_buf[27:0], code} : m_buf;
        pc  = m_cnt + (acc ? 1 : 0);
        fl  = (enb && flsh) || (m_prev_enb && !enb);
        em  = (acc && pc == 15) || (fl && pc != 0);
        if (em) begin
            if (m_full && !rdy) begin
                m_ovf = 1'b1;
                if (m_lost < 255) m_lost++;
            end else begin
                new_pkt.b = pb;
                new_pkt.c = 4'(pc);
                sb.push_back(new_pkt);
                m_full = 1'b1;
            end
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        m_buf      = em ? '0 : pb;
        m_cnt      = em ? 0 : pc;
        m_prev_enb = enb;
        @(posedge clk);
        @(negedge clk);
        check_eq("dct_count", 32'(dct_count), 32'(m_cnt));
        check_eq("dct_buffer", 32'(dct_buffer), 32'(m_buf));
        check_eq("pkt_valid", 32'(pkt_valid), 32'(m_full));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("lost_cnt", 32'(lost_cnt), 32'(m_lost));
    endtask

    // Reset with every other input active to show reset priority
    task automatic do_reset();
        reset_n   = 1'b0;
        trc_enb   = 1'b1;
        dct_valid = 1'b1;
        dct_code  = 2'b10;
        flush     = 1'b1;
        pkt_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_dct_buffer", 32'(dct_buffer), 32'd0);
        check_eq("rst_dct_count", 32'(dct_count), 32'd0);
        check_eq("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check_eq("rst_pkt_buffer", 32'(pkt_buffer), 32'd0);
        check_eq("rst_pkt_count", 32'(pkt_count), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_lost_cnt", 32'(lost_cnt), 32'd0);
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        reset_n   = 1'b0;
        trc_enb   = 1'b0;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
        pkt_ready = 1'b0;
        model_clear();
        @(posedge clk);
        do_reset();

        // Full packet of taken codes, first accept right after reset
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        check_eq("full_valid", 32'(pkt_valid), 32'd1);
        check_eq("full_buffer", 32'(pkt_buffer), 32'h2AAAAAAA);
        check_eq("full_count", 32'(pkt_count), 32'd15);
        check_eq("full_dct_count", 32'(dct_count), 32'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Partial packet by flush, then an empty flush
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        check_eq("flush_count", 32'(pkt_count), 32'd3);
        check_eq("flush_buffer", 32'(pkt_buffer), 32'h0000001E);
        cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        check_eq("empty_flush_valid", 32'(pkt_valid), 32'd0);

        // Accept and flush together include the code
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        check_eq("accflush_count", 32'(pkt_count), 32'd5);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Trace disable flushes the partial; inputs ignored while disabled
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check_eq("disable_valid", 32'(pkt_valid), 32'd1);
        check_eq("disable_count", 32'(pkt_count), 32'd3);
        cycle(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        check_eq("disabled_dct_count", 32'(dct_count), 32'd0);

        // Replace held packet with no bubble
        do_reset();
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        check_eq("replace_valid", 32'(pkt_valid), 32'd1);
        check_eq("replace_buffer", 32'(pkt_buffer), 32'h2);
        check_eq("replace_count", 32'(pkt_count), 32'd1);
        check_eq("replace_lost", 32'(lost_cnt), 32'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Drops while stalled, then saturation
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        check_eq("drop_hold_buffer", 32'(pkt_buffer), 32'h5);
        check_eq("drop_hold_count", 32'(pkt_count), 32'd2);
        check_eq("drop_overflow", 32'(overflow), 32'd1);
        check_eq("drop_lost", 32'(lost_cnt), 32'd1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 2'b11, 1'b1, 1'b0);
        check_eq("sat_lost", 32'(lost_cnt), 32'd255);
        check_eq("sat_hold_buffer", 32'(pkt_buffer), 32'h5);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Reset mid-packet with a held packet, then reserved code is ignored
        do_reset();
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        check_eq("pre_reset_count", 32'(dct_count), 32'd7);
        do_reset();
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        check_eq("rsvd_count", 32'(dct_count), 32'd1);
        check_eq("rsvd_buffer", 32'(dct_buffer), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
